// File: rtl/bus_ram_responder_if.sv
// Data-bus request/acknowledge bundle between a memory-stage initiator and a RAM responder.
interface bus_ram_responder_if;
  logic        bus_cyc;
  logic        bus_we;
  logic [31:0] bus_adr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_in;
  logic [31:0] bus_out;
  logic        bus_ack;

  modport master (
    output bus_cyc, bus_we, bus_adr, bus_sel, bus_in,
    input  bus_out, bus_ack
  );

  modport slave (
    input  bus_cyc, bus_we, bus_adr, bus_sel, bus_in,
    output bus_out, bus_ack
  );
endinterface

// File: rtl/bus_ram_responder.sv
// Word-organised single-port RAM responder: captures a bus request, waits WAIT_STATES
// cycles, performs a lane-masked write or full-word read, then pulses bus_ack.
module bus_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  bus_ram_responder_if.slave bus,
  output logic               busy_o
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned WCNT_W = 4;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [LANES-1:0]      sel;
    logic [31:0]           data;
  } req_t;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  req_t               req_q, req_d;
  logic [31:0]        bus_out_q, bus_out_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               access_c;
  logic [31:0]        mem [DEPTH];

  // Next-state, request capture and the access that happens on ACK entry
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    req_d     = req_q;
    bus_out_d = bus_out_q;
    access_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.bus_cyc) begin
          req_d.we   = bus.bus_we;
          req_d.adr  = bus.bus_adr[ADDR_WIDTH+1:2];
          req_d.sel  = bus.bus_sel;
          req_d.data = bus.bus_in;
          wcnt_d     = WCNT_W'(WAIT_STATES);
          state_d    = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (!bus.bus_cyc) begin
          state_d = S_IDLE;
        end else if (wcnt_q == WCNT_W'(1)) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ACK always returns to IDLE, so a next state of ACK means ACK entry
    access_c = (state_d == S_ACK);
    if (access_c && !req_d.we) begin
      bus_out_d = mem[req_d.adr];
    end

    ack_d  = access_c;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      req_q     <= '0;
      bus_out_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      req_q     <= req_d;
      bus_out_q <= bus_out_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  // RAM array is not reset; gating on rst_n_i keeps a write from landing while reset is held
  always_ff @(posedge clk_i) begin
    if (access_c && req_d.we && rst_n_i) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (req_d.sel[i]) begin
          mem[req_d.adr][8*i +: 8] <= req_d.data[8*i +: 8];
        end
      end
    end
  end

  assign bus.bus_out = bus_out_q;
  assign bus.bus_ack = ack_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed self-checking bench for bus_ram_responder with WAIT_STATES 0 and 3.
module tb_bus_ram_responder;

  logic clk = 1'b0;
  logic rst0_n = 1'b1;
  logic rst3_n = 1'b1;
  logic busy0, busy3;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_rd0 = 32'h0;

  bus_ram_responder_if bi0 ();
  bus_ram_responder_if bi3 ();

  bus_ram_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_ws0 (
    .clk_i   (clk),
    .rst_n_i (rst0_n),
    .bus     (bi0),
    .busy_o  (busy0)
  );

  bus_ram_responder #(.ADDR_WIDTH(12), .WAIT_STATES(3)) u_ws3 (
    .clk_i   (clk),
    .rst_n_i (rst3_n),
    .bus     (bi3),
    .busy_o  (busy3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr0(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] data);
    bi0.bus_cyc = 1'b1; bi0.bus_we = 1'b1; bi0.bus_adr = adr; bi0.bus_sel = sel; bi0.bus_in = data;
    tick();
    chk("ws0_wr_ack", 32'(bi0.bus_ack), 32'd1);
    chk("ws0_wr_out_hold", bi0.bus_out, last_rd0);
    bi0.bus_cyc = 1'b0;
    tick();
    chk("ws0_wr_ack_drop", 32'(bi0.bus_ack), 32'd0);
  endtask

  task automatic rd0(input logic [31:0] adr, input logic [31:0] exp);
    bi0.bus_cyc = 1'b1; bi0.bus_we = 1'b0; bi0.bus_adr = adr; bi0.bus_sel = 4'h0; bi0.bus_in = 32'h0;
    tick();
    chk("ws0_rd_ack", 32'(bi0.bus_ack), 32'd1);
    chk("ws0_rd_data", bi0.bus_out, exp);
    last_rd0 = exp;
    bi0.bus_cyc = 1'b0;
    tick();
    chk("ws0_rd_ack_drop", 32'(bi0.bus_ack), 32'd0);
    chk("ws0_rd_data_hold", bi0.bus_out, exp);
  endtask

  // Full WS=3 transaction: busy in N+1..N+4, ack only in N+4
  task automatic xfer3(input logic we, input logic [31:0] adr, input logic [31:0] data,
                       input logic [31:0] exp_out);
    bi3.bus_cyc = 1'b1; bi3.bus_we = we; bi3.bus_adr = adr; bi3.bus_sel = 4'hF; bi3.bus_in = data;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("ws3_busy", 32'(busy3), 32'd1);
      chk("ws3_ack_timing", 32'(bi3.bus_ack), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("ws3_out", bi3.bus_out, exp_out);
    bi3.bus_cyc = 1'b0;
    tick();
    chk("ws3_ack_width", 32'(bi3.bus_ack), 32'd0);
    chk("ws3_busy_clear", 32'(busy3), 32'd0);
  endtask

  initial begin
    bi0.bus_cyc = 1'b0; bi0.bus_we = 1'b0; bi0.bus_adr = '0; bi0.bus_sel = '0; bi0.bus_in = '0;
    bi3.bus_cyc = 1'b0; bi3.bus_we = 1'b0; bi3.bus_adr = '0; bi3.bus_sel = '0; bi3.bus_in = '0;

    // Reset values
    #2;
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    #1;
    chk("rst_ack0", 32'(bi0.bus_ack), 32'd0);
    chk("rst_out0", bi0.bus_out, 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_ack3", 32'(bi3.bus_ack), 32'd0);
    chk("rst_out3", bi3.bus_out, 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    tick();
    tick();
    rst0_n = 1'b1;
    rst3_n = 1'b1;

    // WS=0 full word, byte lane, halfword, empty sel, upper-address alias
    wr0(32'h10, 4'hF, 32'hDEADBEEF);
    rd0(32'h10, 32'hDEADBEEF);
    wr0(32'h11, 4'b0100, 32'h00AA0000);
    rd0(32'h10, 32'hDEAABEEF);
    wr0(32'h10, 4'b0011, 32'h00001234);
    rd0(32'h10, 32'hDEAA1234);
    wr0(32'h10, 4'b0000, 32'hFFFFFFFF);
    rd0(32'h10, 32'hDEAA1234);
    rd0(32'h4010, 32'hDEAA1234);

    // Back-to-back with bus_cyc held: acks in N+1 and N+3
    bi0.bus_cyc = 1'b1; bi0.bus_we = 1'b1; bi0.bus_adr = 32'h20; bi0.bus_sel = 4'hF; bi0.bus_in = 32'h1;
    tick();
    chk("b2b_ack1", 32'(bi0.bus_ack), 32'd1);
    bi0.bus_we = 1'b0; bi0.bus_in = 32'hFFFF0000;
    tick();
    chk("b2b_idle_gap", 32'(bi0.bus_ack), 32'd0);
    chk("b2b_busy_gap", 32'(busy0), 32'd0);
    tick();
    chk("b2b_ack2", 32'(bi0.bus_ack), 32'd1);
    chk("b2b_rd_data", bi0.bus_out, 32'h00000001);
    bi0.bus_cyc = 1'b0;
    tick();
    chk("b2b_ack_drop", 32'(bi0.bus_ack), 32'd0);

    // WS=3 latency
    xfer3(1'b1, 32'h30, 32'hCAFEF00D, 32'h0);
    xfer3(1'b0, 32'h30, 32'h0, 32'hCAFEF00D);

    // WS=3 abort: bus_cyc dropped in N+2
    bi3.bus_cyc = 1'b1; bi3.bus_we = 1'b1; bi3.bus_adr = 32'h30; bi3.bus_sel = 4'hF; bi3.bus_in = 32'h55;
    tick();
    tick();
    chk("abort_busy_n2", 32'(busy3), 32'd1);
    bi3.bus_cyc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_ack", 32'(bi3.bus_ack), 32'd0);
      chk("abort_idle", 32'(busy3), 32'd0);
    end
    xfer3(1'b0, 32'h30, 32'h0, 32'hCAFEF00D);

    // WS=3 reset mid-wait: prime 0x40 and a nonzero bus_out first
    xfer3(1'b1, 32'h40, 32'hA5A5A5A5, 32'hCAFEF00D);
    xfer3(1'b0, 32'h40, 32'h0, 32'hA5A5A5A5);
    bi3.bus_cyc = 1'b1; bi3.bus_we = 1'b1; bi3.bus_adr = 32'h40; bi3.bus_sel = 4'hF; bi3.bus_in = 32'h12345678;
    tick();
    tick();
    rst3_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(bi3.bus_ack), 32'd0);
    chk("mid_rst_out", bi3.bus_out, 32'd0);
    chk("mid_rst_busy", 32'(busy3), 32'd0);
    bi3.bus_cyc = 1'b0;
    tick();
    rst3_n = 1'b1;
    xfer3(1'b0, 32'h40, 32'h0, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_ram_responder.md
# bus_ram_responder

Responder end of the pipeline's data bus: a single-port, word-organised RAM that answers the `bus_cyc`/`bus_we`/`bus_sel`/`bus_ack` requests issued by the memory stage. It latches each request, inserts a parameterised number of wait states, and performs the byte-lane-masked write or full-word read. It then returns a one-cycle `bus_ack` that releases the stage's stall. It sits on the data-bus fabric beside other memory-mapped responders.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits. Capacity is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, default 0: extra cycles between request capture and ack. Range 0–15.
- `clk_i` in 1: the block's single clock. All state changes on the rising edge.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `bus_cyc` in 1: request valid. The initiator holds it until it samples ack.
- `bus_we` in 1: 1 = write, 0 = read.
- `bus_adr` in 32: byte address. `bus_adr[ADDR_WIDTH+1:2]` selects the word. Bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so upper-address aliasing is intended.
- `bus_sel` in 4: byte-lane enables. `bus_sel[3]` = bits 31:24 (byte offset 0, big-endian), down to `bus_sel[0]` = bits 7:0 (offset 3).
- `bus_in` in 32: write data from the initiator.
- `bus_out` out 32: read data. Registered.
- `bus_ack` out 1: transaction complete. Registered, one-cycle pulse.
- `busy_o` out 1: high while a request is captured and not yet acked. Used for debug and performance counting.

## Operation
- The FSM has three states: IDLE, WAIT, ACK.
- **IDLE:**
  - If `bus_cyc`=1 at an edge, capture adr/we/sel/`bus_in` into request registers and load `wcnt` = WAIT_STATES.
  - Go to ACK if WAIT_STATES=0, else go to WAIT.
- **WAIT:**
  - Decrement `wcnt` each edge.
  - When `wcnt`=1 and `bus_cyc`=1, go to ACK.
  - If `bus_cyc`=0 at any WAIT edge, the request is aborted: go to IDLE, no write, no ack.
- **Transition into ACK:** the memory access occurs on that edge, using the captured request.
  - Write: update only the lanes whose captured sel bit is 1. Other lanes keep their old value.
  - Read: `bus_out` <= the full stored word, regardless of sel. The initiator extracts the bytes it needs.
  - Write: `bus_out` <= the previous `bus_out` (unchanged).
- **ACK:** `bus_ack`=1 for exactly this one cycle. The next state is always IDLE, whatever `bus_cyc` is.
- A request still asserted in the cycle after ACK is a new transaction. The initiator advances on ack and may present its next request immediately. It is captured in IDLE on the following edge.
- Changes to `bus_adr`/`bus_we`/`bus_sel`/`bus_in` after capture are ignored until the next IDLE capture.
- `busy_o` = (state != IDLE).
- RAM contents are not reset. After a read, `bus_out` holds its value until the next read completes.

## Timing
- **Reset (async, `rst_n_i`=0):** state=IDLE, `bus_ack`=0, `bus_out`=0, `busy_o`=0, `wcnt`=0, request registers cleared.
  - Reset during WAIT or ACK abandons the request. A pending write is not committed.
  - Deassertion is synchronised by the system reset tree. The first capture can occur at the first edge after release.
- **Latency:** `bus_cyc` first high in cycle N (with state IDLE) gives `bus_ack`=1 in cycle N+1+WAIT_STATES.
  - The initiator therefore stalls for 1+WAIT_STATES cycles.
- **Throughput:** one transaction per 2+WAIT_STATES cycles with `bus_cyc` held continuously high. The mandatory IDLE cycle follows every ack.
- **Write visibility:** a read captured in the IDLE cycle immediately after a write's ACK returns the new data, with no hazard.
- **Read data:** `bus_out` is valid in the ack cycle and stable afterward until the next completed read.
- **Aborts:** `bus_cyc` dropping in the ACK cycle itself does not cancel the access; it already happened at ACK entry. Only a WAIT-state drop aborts.
- **Lanes:** `bus_sel`=0 on a write still acks and leaves memory unchanged.

## Test plan
- **WS=0, full-word write then read:**
  - Write adr 0x10, sel 0xF, data 0xDEADBEEF -> ack in cycle N+1.
  - Read adr 0x10 -> ack 1 cycle after capture, `bus_out`=0xDEADBEEF.
- **Byte lanes:**
  - After the word above, write adr 0x11, sel 0b0100, data 0x00AA0000.
  - Read adr 0x10 -> 0xDEAABEEF.
  - Then halfword write sel 0b0011, data 0x00001234 -> read 0xDEAA1234.
- **WS=3 latency:** read with `bus_cyc` held -> `bus_ack` exactly in cycle N+4, `busy_o` high in cycles N+1..N+4, ack pulse width 1.
- **Back-to-back (WS=0):**
  - Hold `bus_cyc` high across write 0x20=0x1 then read 0x20, changing adr/we in the cycle after the first ack.
  - Required: acks in cycles N+1 and N+3, read returns 0x00000001.
- **Abort (WS=3):** write 0x30=0x55 with `bus_cyc` dropped in cycle N+2 -> no ack; a later read of 0x30 returns the prior contents.
- **Reset mid-wait (WS=3):**
  - Assert `rst_n_i`=0 in cycle N+2 of a write -> `bus_ack`, `bus_out`, `busy_o` go to 0 immediately, asynchronously.
  - The write is not committed, and the first post-reset request completes with normal latency.
